// File: rtl/aes_rcon_subword_unit.sv
// AES-128 key-schedule helper: registered round-constant sequencer plus a
// combinational RotWord+SubWord path built from four forward S-box lookups.
module aes_rcon_subword_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        kld,
  input  logic        enable,
  input  logic [31:0] word_in,
  output logic [31:0] rcon,
  output logic [31:0] subword
);

  logic [3:0] idx_q, idx_d;
  logic [7:0] rc_q, rc_d;

  function automatic logic [7:0] rc_lut(input logic [3:0] i);
    logic [7:0] r;
    r = 8'h00;
    case (i)
      4'd0: r = 8'h01;
      4'd1: r = 8'h02;
      4'd2: r = 8'h04;
      4'd3: r = 8'h08;
      4'd4: r = 8'h10;
      4'd5: r = 8'h20;
      4'd6: r = 8'h40;
      4'd7: r = 8'h80;
      4'd8: r = 8'h1b;
      4'd9: r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] s;
    s = 8'h00;
    case (b)
      8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
      8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
      8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
      8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
      8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
      8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
      8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
      8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
      8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
      8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
      8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
      8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
      8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
      8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
      8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
      8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
      8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
      8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
      8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
      8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
      8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
      8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
      8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
      8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
      8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
      8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
      8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
      8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
      8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
      8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
      8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
      8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

  // kld wins over enable; the index saturates at 10, where rc reads as 00
  always_comb begin
    idx_d = idx_q;
    rc_d  = rc_q;
    if (kld) begin
      idx_d = 4'd0;
      rc_d  = 8'h01;
    end else if (enable && (idx_q < 4'd10)) begin
      idx_d = idx_q + 4'd1;
      rc_d  = rc_lut(idx_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= 4'd0;
      rc_q  <= 8'h01;
    end else begin
      idx_q <= idx_d;
      rc_q  <= rc_d;
    end
  end

  assign rcon = {rc_q, 24'h000000};

  // RotWord folded into the byte routing: byte 3 of word_in lands in byte 0
  assign subword = {sbox(word_in[23:16]), sbox(word_in[15:8]),
                    sbox(word_in[7:0]),   sbox(word_in[31:24])};

endmodule

// File: tb/tb_aes_rcon_subword_unit.sv
// Directed bench for aes_rcon_subword_unit: rcon sequencing, kld/enable/reset
// behaviour, S-box contents and a full AES-128 key expansion.
module tb_aes_rcon_subword_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        kld;
  logic        enable;
  logic [31:0] word_in;
  logic [31:0] rcon;
  logic [31:0] subword;

  int errors = 0;
  int checks = 0;

  logic [7:0]   sref [256];
  logic [127:0] srows [16];
  logic [31:0]  w0, w1, w2, w3, exp_sub;
  logic [7:0]   bb;

  aes_rcon_subword_unit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .kld     (kld),
    .enable  (enable),
    .word_in (word_in),
    .rcon    (rcon),
    .subword (subword)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round constant by index, built by repeated GF(2^8) doubling
  function automatic logic [31:0] rc_model(input int i);
    logic [7:0] r;
    if (i >= 10) return 32'h0;
    r = 8'h01;
    for (int k = 0; k < i; k++) r = r[7] ? ((r << 1) ^ 8'h1b) : (r << 1);
    return {r, 24'h0};
  endfunction

  initial begin
    srows[0]  = 128'h637c777bf26b6fc53001672bfed7ab76;
    srows[1]  = 128'hca82c97dfa5947f0add4a2af9ca472c0;
    srows[2]  = 128'hb7fd9326363ff7cc34a5e5f171d83115;
    srows[3]  = 128'h04c723c31896059a071280e2eb27b275;
    srows[4]  = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
    srows[5]  = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
    srows[6]  = 128'hd0efaafb434d338545f9027f503c9fa8;
    srows[7]  = 128'h51a3408f929d38f5bcb6da2110fff3d2;
    srows[8]  = 128'hcd0c13ec5f974417c4a77e3d645d1973;
    srows[9]  = 128'h60814fdc222a908846eeb814de5e0bdb;
    srows[10] = 128'he0323a0a4906245cc2d3ac629195e479;
    srows[11] = 128'he7c8376d8dd54ea96c56f4ea657aae08;
    srows[12] = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
    srows[13] = 128'h703eb5664803f60e613557b986c11d9e;
    srows[14] = 128'he1f8981169d98e949b1e87e9ce5528df;
    srows[15] = 128'h8ca1890dbfe6426841992d0fb054bb16;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        sref[r*16 + c] = srows[r][127 - 8*c -: 8];

    // Reset state
    rst_n = 1'b0; kld = 1'b0; enable = 1'b0; word_in = 32'h0;
    #12;
    chk("reset_rcon", {96'h0, rcon}, {96'h0, 32'h0100_0000});
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", {96'h0, rcon}, {96'h0, 32'h0100_0000});

    // kld then 10 enables, then one extra enable
    kld = 1'b1; tick();
    chk("kld_rcon", {96'h0, rcon}, {96'h0, 32'h0100_0000});
    kld = 1'b0; enable = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      chk($sformatf("seq_step%0d", i), {96'h0, rcon}, {96'h0, rc_model(i)});
    end

    // kld together with enable
    kld = 1'b1; enable = 1'b1; tick();
    chk("kld_and_enable", {96'h0, rcon}, {96'h0, 32'h0100_0000});
    kld = 1'b0; tick();
    chk("index0_after_kld_en", {96'h0, rcon}, {96'h0, 32'h0200_0000});
    for (int i = 2; i <= 5; i++) tick();
    chk("five_enables", {96'h0, rcon}, {96'h0, 32'h2000_0000});
    kld = 1'b1; tick();
    chk("kld_mid_sequence", {96'h0, rcon}, {96'h0, 32'h0100_0000});

    // enable low holds mid-sequence
    kld = 1'b0;
    for (int i = 1; i <= 3; i++) tick();
    chk("three_enables", {96'h0, rcon}, {96'h0, 32'h0800_0000});
    enable = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("hold%0d", i), {96'h0, rcon}, {96'h0, 32'h0800_0000});
    end

    // asynchronous reset between edges
    enable = 1'b1; tick();
    chk("pre_async_reset", {96'h0, rcon}, {96'h0, 32'h1000_0000});
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_immediate", {96'h0, rcon}, {96'h0, 32'h0100_0000});
    rst_n = 1'b1; enable = 1'b0;
    tick();
    enable = 1'b1; tick();
    chk("after_async_reset_index0", {96'h0, rcon}, {96'h0, 32'h0200_0000});
    enable = 1'b0;

    // Directed byte LUT values through the top byte of subword
    word_in = 32'h0000_0000; #1; chk("sbox_00", {120'h0, subword[31:24]}, {120'h0, 8'h63});
    word_in = 32'h0001_0000; #1; chk("sbox_01", {120'h0, subword[31:24]}, {120'h0, 8'h7c});
    word_in = 32'h0053_0000; #1; chk("sbox_53", {120'h0, subword[31:24]}, {120'h0, 8'hed});
    word_in = 32'h00ff_0000; #1; chk("sbox_ff", {120'h0, subword[31:24]}, {120'h0, 8'h16});
    word_in = 32'h0010_0000; #1; chk("sbox_10", {120'h0, subword[31:24]}, {120'h0, 8'hca});

    // All 256 entries, each byte lane fed a different permutation of b
    for (int b = 0; b < 256; b++) begin
      bb = 8'(b);
      word_in = {bb ^ 8'h5a, bb, bb ^ 8'ha5, bb ^ 8'h3c};
      #1;
      chk($sformatf("sbox_all_%02h", bb), {96'h0, subword},
          {96'h0, sref[bb], sref[bb ^ 8'ha5], sref[bb ^ 8'h3c], sref[bb ^ 8'h5a]});
    end

    // Round-1 first word of the FIPS-197 example
    kld = 1'b1; tick(); kld = 1'b0;
    word_in = 32'h09cf4f3c; #1;
    chk("subword_09cf4f3c", {96'h0, subword}, {96'h0, 32'h8a84eb01});
    chk("round1_w0", {96'h0, 32'h2b7e1516 ^ subword ^ rcon}, {96'h0, 32'ha0fafe17});

    // Full expansion driven by a bench-side expander model
    w0 = 32'h2b7e1516; w1 = 32'h28aed2a6; w2 = 32'habf71588; w3 = 32'h09cf4f3c;
    kld = 1'b1; tick(); kld = 1'b0; enable = 1'b1;
    for (int r = 1; r <= 10; r++) begin
      word_in = w3;
      #1;
      exp_sub = {sref[w3[23:16]], sref[w3[15:8]], sref[w3[7:0]], sref[w3[31:24]]};
      chk($sformatf("exp_subword_r%0d", r), {96'h0, subword}, {96'h0, exp_sub});
      chk($sformatf("exp_rcon_r%0d", r), {96'h0, rcon}, {96'h0, rc_model(r - 1)});
      w0 = w0 ^ subword ^ rcon;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      tick();
    end
    enable = 1'b0;
    chk("last_round_key", {w0, w1, w2, w3}, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
